universal_shift_reg: RTL and testbench



---
 rtl/usr_pkg.sv | 32 +++
 rtl/universal_shift_reg_if.sv | 37 +++
 rtl/usr_bit_cell.sv | 44 ++++
 rtl/universal_shift_reg.sv | 104 ++++++++++
 tb/tb_universal_shift_reg.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// ============================================================================
// usr_pkg : mode encodings and per-bit cell operations for universal_shift_reg
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_INV  = 3'b111;

  // Per-cell next-value source; shifts and rotates share TAKE_LO/TAKE_HI.
  typedef enum logic [2:0] {
    CELL_HOLD    = 3'd0,
    CELL_LOAD    = 3'd1,
    CELL_TAKE_LO = 3'd2,
    CELL_TAKE_HI = 3'd3,
    CELL_CLR     = 3'd4,
    CELL_INV     = 3'd5
  } cell_op_t;

endpackage

`default_nettype wire

// File: rtl/universal_shift_reg_if.sv
// ============================================================================
// universal_shift_reg_if : command and status bundle of universal_shift_reg
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) ();
  import usr_pkg::*;

  logic                preset;
  logic                en;
  logic [MODE_W-1:0]   mode;
  logic [WIDTH-1:0]    d;
  logic                sin_l;
  logic                sin_r;
  logic [WIDTH-1:0]    q;
  logic                sout_l;
  logic                sout_r;
  logic [CNT_W-1:0]    shift_cnt;
  logic                zero;

  modport master (
    output preset, en, mode, d, sin_l, sin_r,
    input  q, sout_l, sout_r, shift_cnt, zero
  );

  modport slave (
    input  preset, en, mode, d, sin_l, sin_r,
    output q, sout_l, sout_r, shift_cnt, zero
  );

endinterface

`default_nettype wire

// File: rtl/usr_bit_cell.sv
// ============================================================================
// usr_bit_cell : one storage bit with next-value mux, sync reset and preset
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module usr_bit_cell
  import usr_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     reset,
  input  wire logic     preset,
  input  wire logic     preset_bit,
  input  wire cell_op_t op,
  input  wire logic     left_in,
  input  wire logic     right_in,
  input  wire logic     d_bit,
  output logic          q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else if (preset) begin
      r_q <= preset_bit;
    end else begin
      case (op)
        CELL_LOAD:    r_q <= d_bit;
        CELL_TAKE_LO: r_q <= right_in;
        CELL_TAKE_HI: r_q <= left_in;
        CELL_CLR:     r_q <= 1'b0;
        CELL_INV:     r_q <= ~r_q;
        default:      r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/universal_shift_reg.sv
// ============================================================================
// universal_shift_reg : WIDTH-bit load/shift/rotate/clear/invert register
//                       with saturating shift counter and zero flag.
//                       Define USR_ROTATE_EN to enable ROL/ROR modes.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1,
  parameter int               CNT_W      = $clog2(WIDTH + 1)
) (
  input wire logic              clk,
  input wire logic              reset,
  universal_shift_reg_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(WIDTH);

  cell_op_t         w_op;
  logic             w_shift;
  logic             w_cnt_clr;
  logic             w_lo_in;
  logic             w_hi_in;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_from_lo;
  logic [WIDTH-1:0] w_from_hi;
  logic [CNT_W-1:0] r_cnt;

`ifdef USR_ROTATE_EN
  logic w_rot;
`endif

  always_comb begin
    w_op      = CELL_HOLD;
    w_shift   = 1'b0;
    w_cnt_clr = 1'b0;
`ifdef USR_ROTATE_EN
    w_rot     = 1'b0;
`endif
    if (bus.en) begin
      case (bus.mode)
        MODE_LOAD: begin w_op = CELL_LOAD;    w_cnt_clr = 1'b1; end
        MODE_SHL:  begin w_op = CELL_TAKE_LO; w_shift   = 1'b1; end
        MODE_SHR:  begin w_op = CELL_TAKE_HI; w_shift   = 1'b1; end
`ifdef USR_ROTATE_EN
        MODE_ROL:  begin w_op = CELL_TAKE_LO; w_shift = 1'b1; w_rot = 1'b1; end
        MODE_ROR:  begin w_op = CELL_TAKE_HI; w_shift = 1'b1; w_rot = 1'b1; end
`endif
        MODE_CLR:  begin w_op = CELL_CLR;     w_cnt_clr = 1'b1; end
        MODE_INV:  w_op = CELL_INV;
        default:   w_op = CELL_HOLD;
      endcase
    end
  end

  // End cells see the serial inputs, or the wrapped opposite end when rotating.
`ifdef USR_ROTATE_EN
  assign w_lo_in = w_rot ? w_q[WIDTH-1] : bus.sin_l;
  assign w_hi_in = w_rot ? w_q[0]       : bus.sin_r;
`else
  assign w_lo_in = bus.sin_l;
  assign w_hi_in = bus.sin_r;
`endif

  assign w_from_lo = {w_q[WIDTH-2:0], w_lo_in};
  assign w_from_hi = {w_hi_in, w_q[WIDTH-1:1]};

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      usr_bit_cell u_cell (
        .clk        (clk),
        .reset      (reset),
        .preset     (bus.preset),
        .preset_bit (PRESET_VAL[i]),
        .op         (w_op),
        .left_in    (w_from_hi[i]),
        .right_in   (w_from_lo[i]),
        .d_bit      (bus.d[i]),
        .q          (w_q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || bus.preset || w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_shift && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.q         = w_q;
  assign bus.sout_l    = w_q[WIDTH-1];
  assign bus.sout_r    = w_q[0];
  assign bus.shift_cnt = r_cnt;
  assign bus.zero      = (w_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// ============================================================================
// tb_universal_shift_reg : directed vector bench for universal_shift_reg
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;

  universal_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  universal_shift_reg #(
    .WIDTH      (WIDTH),
    .PRESET_VAL (8'hFF),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             pre;
    logic             en;
    logic             rnd;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sl;
    logic             sr;
    logic [WIDTH-1:0] exp_q;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(logic rst, logic pre, logic en, logic [2:0] mode,
                              logic [WIDTH-1:0] d, logic sl, logic sr,
                              logic [WIDTH-1:0] eq, logic [CNT_W-1:0] ec);
    vec_t v;
    v.rst = rst; v.pre = pre; v.en = en; v.rnd = 1'b0; v.mode = mode;
    v.d = d; v.sl = sl; v.sr = sr; v.exp_q = eq; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_outputs(string tag, logic [WIDTH-1:0] eq, logic [CNT_W-1:0] ec);
    check({tag, ".q"},      32'(bus.q),         32'(eq));
    check({tag, ".cnt"},    32'(bus.shift_cnt), 32'(ec));
    check({tag, ".zero"},   32'(bus.zero),      32'(eq == '0));
    check({tag, ".sout_l"}, 32'(bus.sout_l),    32'(eq[WIDTH-1]));
    check({tag, ".sout_r"}, 32'(bus.sout_r),    32'(eq[0]));
  endtask

  task automatic drive(logic rst, logic pre, logic en, logic [2:0] mode,
                       logic [WIDTH-1:0] d, logic sl, logic sr);
    reset      = rst;
    bus.preset = pre;
    bus.en     = en;
    bus.mode   = mode;
    bus.d      = d;
    bus.sin_l  = sl;
    bus.sin_r  = sr;
  endtask

  initial begin
    vec_t v;
    logic [WIDTH-1:0] sh;
    n_checks = 0;
    n_fail   = 0;
    drive(1'b1, 1'b0, 1'b0, MODE_HOLD, '0, 1'b0, 1'b0);

    // Reset with random inputs, then the basic load/shift checks.
    v = mk(1, 0, 0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0); v.rnd = 1'b1;
    vecs.push_back(v);
    vecs.push_back(v);
    vecs.push_back(mk(0, 0, 1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h4B, 1));
    vecs.push_back(mk(0, 0, 1, MODE_SHR,  8'h00, 0, 0, 8'h25, 2));
    vecs.push_back(mk(0, 0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0));
`ifdef USR_ROTATE_EN
    vecs.push_back(mk(0, 0, 1, MODE_ROL,  8'h00, 0, 0, 8'h03, 1));
    vecs.push_back(mk(0, 0, 1, MODE_ROR,  8'h00, 0, 0, 8'h81, 2));
    vecs.push_back(mk(0, 0, 0, MODE_LOAD, 8'h3C, 0, 0, 8'h81, 2));
`else
    vecs.push_back(mk(0, 0, 1, MODE_ROL,  8'h00, 0, 0, 8'h81, 0));
    vecs.push_back(mk(0, 0, 1, MODE_ROR,  8'h00, 0, 0, 8'h81, 0));
    vecs.push_back(mk(0, 0, 0, MODE_LOAD, 8'h3C, 0, 0, 8'h81, 0));
`endif
    vecs.push_back(mk(0, 1, 0, MODE_HOLD, 8'h00, 0, 0, 8'hFF, 0));
    vecs.push_back(mk(1, 1, 1, MODE_LOAD, 8'h77, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'hFF, 0));
    for (int k = 1; k <= 10; k++) begin
      sh = (k >= WIDTH) ? 8'h00 : 8'(8'hFF << k);
      vecs.push_back(mk(0, 0, 1, MODE_SHL, 8'h00, 0, 0, sh, CNT_W'((k > 8) ? 8 : k)));
    end
    vecs.push_back(mk(0, 0, 1, MODE_LOAD, 8'h5A, 0, 0, 8'h5A, 0));
    vecs.push_back(mk(0, 0, 1, MODE_INV,  8'h00, 0, 0, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 1, MODE_SHR,  8'h00, 0, 1, 8'hD2, 1));
    vecs.push_back(mk(0, 0, 1, MODE_INV,  8'h00, 0, 0, 8'h2D, 1));
    vecs.push_back(mk(0, 0, 1, MODE_HOLD, 8'hFF, 1, 1, 8'h2D, 1));
    vecs.push_back(mk(0, 0, 1, MODE_CLR,  8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h01, 1));
    vecs.push_back(mk(0, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h03, 2));
    vecs.push_back(mk(1, 0, 1, MODE_SHL,  8'h00, 1, 0, 8'h00, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      v = vecs[i];
      if (v.rnd)
        drive(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom));
      else
        drive(v.rst, v.pre, v.en, v.mode, v.d, v.sl, v.sr);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), v.exp_q, v.exp_cnt);
    end

    // Preset, then SHR past saturation, then disabled shifts must not count.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, MODE_HOLD, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_outputs("seq_preset", 8'hFF, 0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, MODE_SHR, '0, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_outputs($sformatf("seq_shr%0d", k),
                    (k >= WIDTH) ? 8'h00 : 8'(8'hFF >> k), CNT_W'((k > 8) ? 8 : k));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, MODE_SHR, 8'h12, 1'b1, 1'b1);
      @(posedge clk); #1;
      check_outputs($sformatf("seq_dis%0d", k), 8'h00, 8);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, MODE_INV, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_outputs("seq_inv_sat", 8'hFF, 8);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, MODE_SHL, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_outputs("seq_preset2", 8'hFF, 0);

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, MODE_HOLD, '0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
